// File: rtl/piezo_melody_player.sv
// piezo_melody_player
// RAM-backed multi-song note sequencer driving a square-wave piezo pin.
// The note RAM is split into 2^SONG_W equal segments, one per song. Each entry
// is {div, dur, last}: div = tone half-period in clk cycles (0 = rest),
// dur = length in ticks of TICK_DIV clk cycles (0 = skip entry),
// last = final note of the song. The top entry of a segment is always last.
// Optional build macro: MELODY_RETRIGGER_EN. When it is defined, start while
// busy restarts playback at the newly selected song. Otherwise start is only
// honoured in IDLE.
// Requires SONG_W < ADDR_W so that note_idx has at least one bit.

module piezo_melody_player #(
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 12,
    parameter int ADDR_W   = 5,
    parameter int SONG_W   = 2,
    parameter int TICK_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DIV_W-1:0]         wr_div,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     wr_last,
    input  logic                     start,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     loop,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-SONG_W-1:0] note_idx,
    output logic                     piezo_out
);

    localparam int SEG_W = ADDR_W - SONG_W;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ENT_W = DIV_W + DUR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;

    // Note RAM and its synchronous read register
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [ENT_W-1:0]  r_rd_q;

    // Sequencer state
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [SONG_W-1:0] r_song;
    logic              r_loop;
    logic              r_done;

    // Latched current note
    logic [DIV_W-1:0]  r_div;
    logic [DUR_W-1:0]  r_dur;
    logic              r_last;

    // Playback counters and output
    logic [PRE_W-1:0]  r_pre;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic [DIV_W-1:0]  r_tone;
    logic              r_piezo;

    // Decoded RAM word and next-state signals
    logic [DIV_W-1:0]  w_rd_div;
    logic [DUR_W-1:0]  w_rd_dur;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_new_base;
    logic [ADDR_W-1:0] w_cur_base;
    logic              w_seg_end;
    logic              w_tick_wrap;
    logic              w_dur_done;
    logic              w_start_ok;
    logic              w_last;
    logic              w_note_end;
    logic              w_stay_play;
    logic [1:0]        w_nxt_state;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic              w_nxt_done;

    assign w_rd_div   = r_rd_q[ENT_W-1 -: DIV_W];
    assign w_rd_dur   = r_rd_q[DUR_W:1];
    assign w_rd_last  = r_rd_q[0];

    assign w_new_base = {song_sel, SEG_W'(0)};
    assign w_cur_base = {r_song, SEG_W'(0)};
    assign w_seg_end  = &r_addr[SEG_W-1:0];

    // A note ends on the last prescaler cycle of its last tick
    assign w_tick_wrap = (r_pre == PRE_W'(TICK_DIV - 1));
    assign w_dur_done  = w_tick_wrap && (r_dur_cnt == r_dur - DUR_W'(1));

`ifdef MELODY_RETRIGGER_EN
    assign w_start_ok = start;
`else
    assign w_start_ok = start && (r_state == S_IDLE);
`endif

    // Next state / next address; stop overrides start, start overrides the sequencer
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_addr;
        w_nxt_done  = 1'b0;
        w_last      = 1'b0;
        w_note_end  = 1'b0;

        case (r_state)
            S_FETCH: begin
                // RAM word is valid during FETCH; a zero-length entry ends here
                w_last     = w_rd_last | w_seg_end;
                w_note_end = (w_rd_dur == '0);
                if (!w_note_end)
                    w_nxt_state = S_PLAY;
            end
            S_PLAY: begin
                w_last     = r_last | w_seg_end;
                w_note_end = w_dur_done;
            end
            default: ;
        endcase

        if (w_note_end) begin
            if (!w_last) begin
                w_nxt_addr  = r_addr + ADDR_W'(1);
                w_nxt_state = S_FETCH;
            end else if (r_loop) begin
                w_nxt_addr  = w_cur_base;
                w_nxt_state = S_FETCH;
            end else begin
                w_nxt_state = S_IDLE;
                w_nxt_done  = 1'b1;
            end
        end

        if (w_start_ok) begin
            w_nxt_state = S_FETCH;
            w_nxt_addr  = w_new_base;
            w_nxt_done  = 1'b0;
        end

        if (stop) begin
            w_nxt_state = S_IDLE;
            w_nxt_addr  = r_addr;
            w_nxt_done  = 1'b0;
        end
    end

    // Note RAM: write port plus read of the address about to be fetched, so the
    // word is ready in the FETCH cycle; NBA ordering gives read-before-write
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_addr] <= {wr_div, wr_dur, wr_last};
        r_rd_q <= r_mem[w_nxt_addr];
    end

    // Sequencer registers, song/mode latch and current-note latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_song  <= '0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
            r_div   <= '0;
            r_dur   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_addr  <= w_nxt_addr;
            r_done  <= w_nxt_done;
            if (w_start_ok && !stop) begin
                r_song <= song_sel;
                r_loop <= loop;
            end
            if (r_state == S_FETCH) begin
                r_div  <= w_rd_div;
                r_dur  <= w_rd_dur;
                r_last <= w_rd_last;
            end
        end
    end

    // Counters run only while remaining in PLAY; anything else clears them and silences the pin
    assign w_stay_play = (r_state == S_PLAY) && (w_nxt_state == S_PLAY);

    // Tick prescaler, duration counter and tone divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre     <= '0;
            r_dur_cnt <= '0;
            r_tone    <= '0;
            r_piezo   <= 1'b0;
        end else if (!w_stay_play) begin
            r_pre     <= '0;
            r_dur_cnt <= '0;
            r_tone    <= '0;
            r_piezo   <= 1'b0;
        end else begin
            if (w_tick_wrap) begin
                r_pre     <= '0;
                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end

            if (r_div == '0) begin
                r_tone  <= '0;
                r_piezo <= 1'b0;
            end else if (r_tone == r_div - DIV_W'(1)) begin
                r_tone  <= '0;
                r_piezo <= ~r_piezo;
            end else begin
                r_tone <= r_tone + DIV_W'(1);
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign note_idx  = r_addr[SEG_W-1:0];
    assign piezo_out = r_piezo;

endmodule

// File: tb/tb_piezo_melody_player.sv
// Scoreboard bench for piezo_melody_player (TICK_DIV=4, SEG=8).
// Stimulus pushes the expected {busy, done, note_idx, piezo_out} for each
// checked cycle; the monitor pops and compares on every falling edge.

module tb_piezo_melody_player;

    localparam int DIV_W    = 16;
    localparam int DUR_W    = 12;
    localparam int ADDR_W   = 5;
    localparam int SONG_W   = 2;
    localparam int TICK_DIV = 4;
    localparam int SEG_W    = ADDR_W - SONG_W;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DIV_W-1:0]    wr_div;
    logic [DUR_W-1:0]    wr_dur;
    logic                wr_last;
    logic                start;
    logic [SONG_W-1:0]   song_sel;
    logic                loop;
    logic                stop;
    logic                busy;
    logic                done;
    logic [SEG_W-1:0]    note_idx;
    logic                piezo_out;

    piezo_melody_player #(
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .ADDR_W  (ADDR_W),
        .SONG_W  (SONG_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_div   (wr_div),
        .wr_dur   (wr_dur),
        .wr_last  (wr_last),
        .start    (start),
        .song_sel (song_sel),
        .loop     (loop),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx),
        .piezo_out(piezo_out)
    );

    logic [5:0] exp_q[$];
    int         tag_q[$];
    int         cur_t;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare one queued expectation per falling edge
    always @(negedge clk) begin
        logic [5:0] e;
        logic [5:0] g;
        int         t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = {busy, done, note_idx, piezo_out};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL test%0d chk%0d: got busy=%0b done=%0b idx=%0d pz=%0b, want busy=%0b done=%0b idx=%0d pz=%0b",
                         t, total, g[5], g[4], g[3:1], g[0], e[5], e[4], e[3:1], e[0]);
            end
        end
    end

    task automatic push(input logic b, input logic d, input int idx, input logic p);
        exp_q.push_back({b, d, 3'(idx), p});
        tag_q.push_back(cur_t);
    endtask

    // One clock: outputs after this edge must match
    task automatic tk(input logic b, input logic d, input int idx, input logic p);
        @(posedge clk);
        #1;
        push(b, d, idx, p);
    endtask

    task automatic wr(input int a, input int dv, input int du, input logic l);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_div  = DIV_W'(dv);
        wr_dur  = DUR_W'(du);
        wr_last = l;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // div=2, dur=2: 8 PLAY cycles, square wave 0,0,1,1,...
    task automatic play8(input int idx);
        for (int p = 0; p < 8; p++) tk(1'b1, 1'b0, idx, (p % 4) >= 2);
    endtask

    // div=0, dur=1: 4 silent PLAY cycles
    task automatic silent4(input int idx);
        for (int p = 0; p < 4; p++) tk(1'b1, 1'b0, idx, 1'b0);
    endtask

    // div=1, dur=1: toggle every cycle 0,1,0,1
    task automatic tog4(input int idx);
        for (int p = 0; p < 4; p++) tk(1'b1, 1'b0, idx, (p % 2) == 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cur_t = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0; wr_last = 1'b0;
        start = 1'b0; song_sel = '0; loop = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        tk(1'b0, 1'b0, 0, 1'b0);
        tk(1'b0, 1'b0, 0, 1'b0);

        // note tables
        wr(0, 2, 2, 1'b0);
        wr(1, 0, 1, 1'b1);
        wr(24, 5, 0, 1'b0);
        wr(25, 1, 1, 1'b1);
        for (int k = 0; k < 8; k++) wr(8 + k, 0, 1, 1'b0);

        // one-shot song 0
        cur_t = 1;
        song_sel = 2'd0; loop = 1'b0; start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        play8(0);
        tk(1'b1, 1'b0, 1, 1'b0);
        silent4(1);
        tk(1'b0, 1'b1, 1, 1'b0);
        tk(1'b0, 1'b0, 1, 1'b0);

        // loop song 0, then stop mid-note
        cur_t = 2;
        loop = 1'b1; start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        play8(0);
        tk(1'b1, 1'b0, 1, 1'b0);
        silent4(1);
        tk(1'b1, 1'b0, 0, 1'b0);
        play8(0);
        tk(1'b1, 1'b0, 1, 1'b0);
        silent4(1);
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b1);
        stop = 1'b1;
        tk(1'b0, 1'b0, 0, 1'b0);
        stop = 1'b0;
        tk(1'b0, 1'b0, 0, 1'b0);

        // song 3: skip entry then fast tone
        cur_t = 3;
        song_sel = 2'd3; loop = 1'b0; start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        tk(1'b1, 1'b0, 1, 1'b0);
        tog4(1);
        tk(1'b0, 1'b1, 1, 1'b0);
        tk(1'b0, 1'b0, 1, 1'b0);

        // song 1: no last flags, ends after entry SEG-1
        cur_t = 4;
        song_sel = 2'd1; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tk(1'b1, 1'b0, k, 1'b0);
            start = 1'b0;
            silent4(k);
        end
        tk(1'b0, 1'b1, 7, 1'b0);
        tk(1'b0, 1'b0, 7, 1'b0);

        // start + stop together from IDLE
        cur_t = 5;
        song_sel = 2'd0; start = 1'b1; stop = 1'b1;
        tk(1'b0, 1'b0, 7, 1'b0);
        start = 1'b0; stop = 1'b0;
        tk(1'b0, 1'b0, 7, 1'b0);

        // start while busy
        cur_t = 6;
        song_sel = 2'd0; loop = 1'b0; start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b0);
        song_sel = 2'd3; start = 1'b1;
`ifdef MELODY_RETRIGGER_EN
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        tk(1'b1, 1'b0, 1, 1'b0);
        tog4(1);
        tk(1'b0, 1'b1, 1, 1'b0);
`else
        tk(1'b1, 1'b0, 0, 1'b1);
        start = 1'b0;
        for (int p = 3; p < 8; p++) tk(1'b1, 1'b0, 0, (p % 4) >= 2);
        tk(1'b1, 1'b0, 1, 1'b0);
        silent4(1);
        tk(1'b0, 1'b1, 1, 1'b0);
`endif

        // async reset mid-PLAY, RAM retained afterwards
        cur_t = 7;
        song_sel = 2'd0; loop = 1'b0; start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b0);
        tk(1'b1, 1'b0, 0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || note_idx !== '0 || piezo_out !== 1'b0) begin
            bad++;
            $display("FAIL test7: outputs not cleared asynchronously: busy=%0b done=%0b idx=%0d pz=%0b",
                     busy, done, note_idx, piezo_out);
        end
        if (dut.r_state !== 2'd0) begin
            bad++;
            $display("FAIL test7: state not IDLE during reset: %0d", dut.r_state);
        end
        push(1'b0, 1'b0, 0, 1'b0);
        tk(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        tk(1'b0, 1'b0, 0, 1'b0);
        tk(1'b0, 1'b0, 0, 1'b0);
        tk(1'b0, 1'b0, 0, 1'b0);
        start = 1'b1;
        tk(1'b1, 1'b0, 0, 1'b0);
        start = 1'b0;
        play8(0);
        tk(1'b1, 1'b0, 1, 1'b0);
        silent4(1);
        tk(1'b0, 1'b1, 1, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad != 0 || total == 0) begin
            $display("FAIL: %0d mismatches over %0d checks", bad, total);
            $fatal(1);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
